// File: rtl/prog_fsm.sv
// Table-programmable FSM engine: run-time writable next-state/output table,
// Moore/Mealy output select, forced-state load, change pulse and dwell counter.
module prog_fsm #(
    parameter int STATE_W = 2,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 5,
    parameter int OIDX_W  = 3,
    parameter int DWELL_W = 8,
    parameter int MEALY   = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [IN_W-1:0]           a,
    input  logic                      force_en,
    input  logic [STATE_W-1:0]        force_state,
    input  logic                      cfg_we,
    input  logic [STATE_W+IN_W-1:0]   cfg_addr,
    input  logic [STATE_W-1:0]        cfg_next,
    input  logic [OIDX_W-1:0]         cfg_out,
    output logic [STATE_W+OIDX_W-1:0] cfg_rdata,
    output logic [STATE_W-1:0]        state,
    output logic [OUT_W-1:0]          y,
    output logic                      changed,
    output logic [DWELL_W-1:0]        dwell
);

    localparam int AW    = STATE_W + IN_W;
    localparam int DEPTH = 1 << AW;

    logic [STATE_W-1:0] tbl_next [DEPTH];
    logic [OIDX_W-1:0]  tbl_out  [DEPTH];

    logic [AW-1:0]      e_addr;
    logic [AW-1:0]      o_addr;
    logic [STATE_W-1:0] e_next;
    logic [OIDX_W-1:0]  o_idx;
    logic [OUT_W-1:0]   y_dec;
    logic [DWELL_W-1:0] dwell_inc;

    assign e_addr    = {state, a};
    assign o_addr    = (MEALY != 0) ? {state, a} : {state, {IN_W{1'b0}}};
    assign e_next    = tbl_next[e_addr];
    assign o_idx     = tbl_out[o_addr];
    assign cfg_rdata = {tbl_next[cfg_addr], tbl_out[cfg_addr]};

    // Out-of-range output indices decode to all-off.
    always_comb begin
        y_dec = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (i < (1 << OIDX_W)) begin
                y_dec[i] = (o_idx == OIDX_W'(i));
            end
        end
    end

    assign dwell_inc = (dwell == {DWELL_W{1'b1}}) ? dwell
                                                   : dwell + DWELL_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_next[i] <= '0;
                tbl_out[i]  <= '0;
            end
        end else if (cfg_we) begin
            tbl_next[cfg_addr] <= cfg_next;
            tbl_out[cfg_addr]  <= cfg_out;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= '0;
            y       <= '0;
            changed <= 1'b0;
            dwell   <= '0;
        end else if (force_en) begin
            state   <= force_state;
            y       <= '0;
            changed <= (force_state != state);
            dwell   <= '0;
        end else if (enable) begin
            state   <= e_next;
            y       <= y_dec;
            changed <= (e_next != state);
            dwell   <= (e_next == state) ? dwell_inc : '0;
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_fsm.sv
// Bench for prog_fsm: Mealy and Moore builds run side by side against a
// table-level behavioural model, plus literal checks from the walkthrough.
module tb_prog_fsm;

    localparam int SW = 2;
    localparam int IW = 2;
    localparam int OW = 5;
    localparam int XW = 3;
    localparam int DW = 8;
    localparam int NE = 1 << (SW + IW);

    logic          clock;
    logic          reset_n;
    logic          enable;
    logic [IW-1:0] a;
    logic          force_en;
    logic [SW-1:0] force_state;
    logic          cfg_we;
    logic [SW+IW-1:0] cfg_addr;
    logic [SW-1:0] cfg_next;
    logic [XW-1:0] cfg_out;

    logic [SW+XW-1:0] rd0, rd1;
    logic [SW-1:0]    st0, st1;
    logic [OW-1:0]    y0, y1;
    logic             ch0, ch1;
    logic [DW-1:0]    dw0, dw1;

    prog_fsm #(.STATE_W(SW), .IN_W(IW), .OUT_W(OW), .OIDX_W(XW),
               .DWELL_W(DW), .MEALY(1)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .a(a),
        .force_en(force_en), .force_state(force_state),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next),
        .cfg_out(cfg_out), .cfg_rdata(rd0), .state(st0), .y(y0),
        .changed(ch0), .dwell(dw0));

    prog_fsm #(.STATE_W(SW), .IN_W(IW), .OUT_W(OW), .OIDX_W(XW),
               .DWELL_W(DW), .MEALY(0)) dut_moore (
        .clock(clock), .reset_n(reset_n), .enable(enable), .a(a),
        .force_en(force_en), .force_state(force_state),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next),
        .cfg_out(cfg_out), .cfg_rdata(rd1), .state(st1), .y(y1),
        .changed(ch1), .dwell(dw1));

    int t_next [NE];
    int t_out  [NE];
    int m_state [2];
    int m_y [2];
    int m_chg [2];
    int m_dw [2];

    int errors = 0;
    int checks = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            t_next[i] = 0;
            t_out[i]  = 0;
        end
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_y[k]     = 0;
            m_chg[k]   = 0;
            m_dw[k]    = 0;
        end
    endtask

    // k=0 is the Mealy build, k=1 the Moore build; lookups use the pre-write table.
    task automatic model_edge();
        int idx, oi, nx, o;
        for (int k = 0; k < 2; k++) begin
            idx = m_state[k] * 4 + int'(a);
            oi  = (k == 0) ? idx : m_state[k] * 4;
            if (force_en) begin
                m_chg[k]   = (int'(force_state) != m_state[k]) ? 1 : 0;
                m_state[k] = int'(force_state);
                m_y[k]     = 0;
                m_dw[k]    = 0;
            end else if (enable) begin
                nx = t_next[idx];
                o  = t_out[oi];
                m_y[k]   = (o < OW) ? (1 << o) : 0;
                m_chg[k] = (nx != m_state[k]) ? 1 : 0;
                if (nx == m_state[k])
                    m_dw[k] = (m_dw[k] < 255) ? m_dw[k] + 1 : 255;
                else
                    m_dw[k] = 0;
                m_state[k] = nx;
            end else begin
                m_chg[k] = 0;
            end
        end
        if (cfg_we) begin
            t_next[cfg_addr] = int'(cfg_next);
            t_out[cfg_addr]  = int'(cfg_out);
        end
    endtask

    task automatic compare_all();
        int erd;
        erd = t_next[cfg_addr] * 8 + t_out[cfg_addr];
        chk("state", int'(st0), m_state[0]);
        chk("y", int'(y0), m_y[0]);
        chk("changed", int'(ch0), m_chg[0]);
        chk("dwell", int'(dw0), m_dw[0]);
        chk("cfg_rdata", int'(rd0), erd);
        chk("moore_state", int'(st1), m_state[1]);
        chk("moore_y", int'(y1), m_y[1]);
        chk("moore_changed", int'(ch1), m_chg[1]);
        chk("moore_dwell", int'(dw1), m_dw[1]);
        chk("moore_cfg_rdata", int'(rd1), erd);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wr(input int addr, input int nx, input int o);
        enable   = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = (SW + IW)'(addr);
        cfg_next = SW'(nx);
        cfg_out  = XW'(o);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run(input int av);
        enable = 1'b1;
        a      = IW'(av);
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b0; a = '0; force_en = 1'b0; force_state = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_next = '0; cfg_out = '0;
        model_reset();
        #2;
        compare_all();
        chk("reset_y", int'(y0), 0);
        #5 reset_n = 1'b1;

        // Default table: self-loop on state 0, output index 0.
        for (int i = 0; i < 4; i++) begin
            run(i);
            chk("dflt_state", int'(st0), 0);
            chk("dflt_y", int'(y0), 1);
            chk("dflt_dwell", int'(dw0), i + 1);
        end

        // Program the 4-state example.
        for (int s = 0; s < 4; s++) begin
            for (int v = 0; v < 4; v++) begin
                int nx, o;
                case (s)
                    0: nx = (v == 0) ? 1 : 2;
                    1: nx = (v == 0 || v == 2) ? 2 : 1;
                    2: nx = (v == 0) ? 1 : (v == 1) ? 0 : 2;
                    default: nx = (v == 0) ? 1 : (v == 1) ? 0 : 3;
                endcase
                o = (s == 1) ? 1 : (s == 3) ? 2 : 0;
                wr(s * 4 + v, nx, o);
            end
        end
        chk("prog_hold_changed", int'(ch0), 0);

        run(0);
        chk("seq1_state", int'(st0), 1);
        chk("seq1_y", int'(y0), 1);
        chk("seq1_chg", int'(ch0), 1);
        run(0);
        chk("seq2_state", int'(st0), 2);
        chk("seq2_y", int'(y0), 2);
        run(1);
        chk("seq3_state", int'(st0), 0);
        chk("seq3_y", int'(y0), 1);
        chk("seq3_chg", int'(ch0), 1);

        for (int i = 0; i < 5; i++) begin
            enable = 1'b0;
            a = IW'($urandom_range(3));
            step();
            chk("frz_state", int'(st0), 0);
            chk("frz_chg", int'(ch0), 0);
        end

        // Saturate dwell on S3 self-loop, then leave.
        force_en = 1'b1; force_state = 2'd3; enable = 1'b1;
        step();
        force_en = 1'b0;
        for (int i = 0; i < 300; i++) run(2);
        chk("sat_dwell", int'(dw0), 255);
        chk("sat_state", int'(st0), 3);
        run(0);
        chk("sat_exit_dwell", int'(dw0), 0);
        chk("sat_exit_state", int'(st0), 1);

        force_en = 1'b1; force_state = 2'd3; enable = 1'b1;
        step();
        chk("force_state", int'(st0), 3);
        chk("force_y", int'(y0), 0);
        chk("force_chg", int'(ch0), 1);
        step();
        chk("reforce_chg", int'(ch0), 0);
        force_state = 2'd1;
        step();
        force_en = 1'b0;

        // Write {1,01} on the same edge it is looked up.
        enable = 1'b1; a = 2'b01;
        cfg_we = 1'b1; cfg_addr = 4'b0101; cfg_next = 2'd3; cfg_out = 3'd7;
        step();
        cfg_we = 1'b0;
        chk("wr_old_state", int'(st0), 1);
        chk("wr_old_y", int'(y0), 2);
        chk("wr_rdata", int'(rd0), 31);
        run(1);
        chk("wr_new_state", int'(st0), 3);
        chk("wr_new_y", int'(y0), 0);

        for (int i = 0; i < 600; i++) begin
            enable      = ($urandom_range(9) < 7);
            force_en    = ($urandom_range(19) == 0);
            force_state = SW'($urandom_range(3));
            a           = IW'($urandom_range(3));
            cfg_we      = ($urandom_range(4) == 0);
            cfg_addr    = (SW + IW)'($urandom_range(NE - 1));
            cfg_next    = SW'($urandom_range(3));
            cfg_out     = XW'($urandom_range(7));
            step();
            if (i == 300) begin
                #2 reset_n = 1'b0;
                model_reset();
                #1 compare_all();
                chk("midreset_rdata", int'(rd0), 0);
                #1 reset_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_fsm.md
Name: prog_fsm

Overview:
- Table-programmable finite state machine engine; next generation of the fixed 4-state, 2-bit-input FSMs used on the board-level labs.
- Transition/output table held in registers and writable at run time, so one RTL block covers any FSM of up to 2^STATE_W states and IN_W input bits.
- Adds Moore/Mealy mode select, forced-state load, a state-change pulse and a dwell counter.
- Sits between switch/debounce inputs and LED/one-hot outputs.

Parameters:
- STATE_W, 2, state register width; number of states = 2^STATE_W.
- IN_W, 2, input vector width.
- OUT_W, 5, width of one-hot output y.
- OIDX_W, 3, width of output index field per table entry.
- DWELL_W, 8, dwell counter width.
- MEALY, 1, 1 = output indexed by {state,a}; 0 = output indexed by {state,0} (Moore).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  advance FSM on this edge when 1; otherwise hold all state-related registers.
- a  in  IN_W  FSM input vector.
- force_en  in  1  load force_state on next edge; priority over enable.
- force_state  in  STATE_W  state to load.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  STATE_W+IN_W  table entry index = {state,a}.
- cfg_next  in  STATE_W  next-state field to write.
- cfg_out  in  OIDX_W  output-index field to write.
- cfg_rdata  out  STATE_W+OIDX_W  combinational read of table[cfg_addr] = {next,out_idx}.
- state  out  STATE_W  current state.
- y  out  OUT_W  registered one-hot output.
- changed  out  1  one-cycle pulse: state changed on the last edge.
- dwell  out  DWELL_W  consecutive enabled steps without a state change, saturating.

Behaviour:
- Reset (async, reset_n=0): state=0, y=0, changed=0, dwell=0; every table entry = {next=0, out_idx=0}.
- Lookup: entry E = table[{state,a}]. Output entry O = MEALY ? E : table[{state,{IN_W{1'b0}}}].
- Edge with force_en=1 (regardless of enable):
  - state <= force_state; y <= 0; dwell <= 0.
  - changed <= (force_state != state).
- Edge with force_en=0, enable=1:
  - state <= E.next.
  - y <= (O.out_idx < OUT_W) ? (1 << O.out_idx) : 0.
  - changed <= (E.next != state).
  - dwell <= (E.next == state) ? sat_inc(dwell) : 0. Saturates at 2^DWELL_W-1; no wrap.
- Edge with force_en=0, enable=0:
  - state, y and dwell hold.
  - changed <= 0.
- Latency:
  - y and state reflect inputs sampled one edge earlier; no combinational path from a to y.
  - cfg_rdata is combinational from cfg_addr.
- Table write:
  - cfg_we=1 writes table[cfg_addr] <= {cfg_next,cfg_out} on the edge, independent of enable/force.
  - Same-edge lookup uses the old entry; the new entry is used from the next edge.
  - cfg_rdata shows the new value after the edge.
- Writes during reset are ignored. Reset mid-operation restores the default table: any loaded program is lost.
- out_idx >= OUT_W is legal and yields y=0 (all-off code).
- Simultaneous force_en and cfg_we: both take effect; the write does not affect the forced state.

Test Plan:
- Reset then enable=1, a=0..3 with default table -> state stays 0, y=5'b00001 after first edge, changed=0, dwell increments 1,2,3,4.
- Program the 4-state table: S0: a=0→1, else→2; S1: a∈{0,2}→2, else→1; S2: 0→1, 1→0, else→2; S3: 0→1, 1→0, else→3. Outputs S0→0, S1→1, S2→0, S3→2. Apply a=00,00,01 from S0 -> state 1,2,0; y one-hot 00001, 00010, 00001; changed=1 each step.
- enable=0 for 5 cycles with varying a -> state, y, dwell frozen; changed=0.
- Self-loop entry held for 300 steps with DWELL_W=8 -> dwell saturates at 255 and stays; first real transition -> dwell=0.
- force_en=1, force_state=3 while enable=1 -> state=3, y=0, changed=1. Repeat force to 3 -> changed=0.
- Write table[{1,2'b01}] on the same edge state=1, a=01 is looked up -> old next used. Next lookup uses the new entry. out_idx=7 -> y=0. MEALY=0 build -> y independent of a.
